// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM control unit: Moore main FSM driving the shared-memory
// datapath, a combinational ALU decoder, memory wait states with a timeout,
// and deterministic handling of undefined encodings.
module multicycle_ctrl_fsm #(
   parameter bit          MEM_WAIT = 1'b1,
   parameter bit          EXT_OPS  = 1'b1,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic       shR,
   input  logic       MemReady,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       RegW,
   output logic       MemW,
   output logic       PCWrite,
   output logic       Branch,
   output logic       LSrc,
   output logic       EscaSrc,
   output logic       NoWrite,
   output logic [1:0] FlagW,
   output logic [2:0] ALUControl,
   output logic       MemErr,
   output logic       Undef,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_BLWB     = 4'd10
   } state_e;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       ready;
   logic       waiting_state;
   logic       timeout;
   logic       alu_active;
   logic [2:0] alu_ctrl;
   logic       alu_nowrite;
   logic       alu_undef;

   // Memory is always ready when wait states are disabled.
   assign ready         = MEM_WAIT ? MemReady : 1'b1;
   assign waiting_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                          (state_q == S_MEMWRITE);
   assign timeout       = waiting_state && !ready && (wait_q >= TIMEOUT_C);
   assign alu_active    = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
   assign State         = state_q;

   // ALU decoder keyed on Funct[4:1]; undefined codes become a harmless no-write.
   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      alu_ctrl    = 3'b000;
      alu_nowrite = 1'b0;
      alu_undef   = 1'b0;
      case (Funct[4:1])
         4'b0100: alu_ctrl = 3'b000;                  // ADD
         4'b0010: alu_ctrl = 3'b001;                  // SUB
         4'b0000: alu_ctrl = 3'b010;                  // AND
         4'b1100: alu_ctrl = 3'b011;                  // ORR
         4'b1101: alu_ctrl = 3'b100;                  // MOV
         4'b1010: begin                               // CMP
            alu_ctrl    = 3'b001;
            alu_nowrite = 1'b1;
         end
         4'b0001: begin                               // EOR
            if (EXT_OPS) alu_ctrl = 3'b101;
            else         alu_undef = 1'b1;
         end
         4'b1110: begin                               // BIC
            if (EXT_OPS) alu_ctrl = 3'b110;
            else         alu_undef = 1'b1;
         end
         4'b1000: begin                               // TST
            if (EXT_OPS) begin
               alu_ctrl    = 3'b010;
               alu_nowrite = 1'b1;
            end else begin
               alu_undef = 1'b1;
            end
         end
         default: alu_undef = 1'b1;
      endcase

      ALUControl = alu_active ? alu_ctrl : 3'b000;
      NoWrite    = alu_active && (alu_nowrite || alu_undef);
      FlagW      = 2'b00;
      if (alu_active && !alu_undef)
         FlagW = {Funct[0], Funct[0] & (alu_ctrl == 3'b000 || alu_ctrl == 3'b001)};
   end

   // Next state and datapath controls; strobes are suppressed while in reset.
   always_comb begin
      state_d   = state_q;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      ImmSrc    = 2'b00;
      RegSrc    = 2'b00;
      RegW      = 1'b0;
      MemW      = 1'b0;
      PCWrite   = 1'b0;
      Branch    = 1'b0;
      LSrc      = 1'b0;
      EscaSrc   = 1'b0;
      MemErr    = 1'b0;
      Undef     = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (timeout) begin
               MemErr = 1'b1;
            end else if (ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: begin
                  Undef   = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXECUTER, S_EXECUTEI: begin
            if (state_q == S_EXECUTEI) ALUSrcB = 2'b01;
            else                       EscaSrc = shR;
            Undef   = alu_undef;
            state_d = NoWrite ? S_FETCH : S_ALUWB;
         end
         S_ALUWB: begin
            RegW    = 1'b1;
            PCWrite = (Rd == 4'hF);
            state_d = S_FETCH;
         end
         S_MEMADR: begin
            ALUSrcB = Funct[5] ? 2'b00 : 2'b01;
            ImmSrc  = 2'b01;
            state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (timeout) begin
               MemErr  = 1'b1;
               state_d = S_FETCH;
            end else if (ready) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            RegW      = 1'b1;
            ResultSrc = 2'b01;
            PCWrite   = (Rd == 4'hF);
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            RegSrc = 2'b10;
            if (timeout) begin
               MemErr  = 1'b1;
               state_d = S_FETCH;
            end else begin
               MemW = 1'b1;
               if (ready) state_d = S_FETCH;
            end
         end
         S_BRANCH: begin
            Branch    = 1'b1;
            ALUSrcB   = 2'b01;
            ImmSrc    = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
            state_d   = Funct[4] ? S_BLWB : S_FETCH;
         end
         S_BLWB: begin
            RegW    = 1'b1;
            LSrc    = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (reset) begin
         IRWrite = 1'b0;
         RegW    = 1'b0;
         MemW    = 1'b0;
         PCWrite = 1'b0;
         Branch  = 1'b0;
         MemErr  = 1'b0;
         Undef   = 1'b0;
      end
   end

   // Wait counter: consecutive non-ready cycles in one waiting state, saturating.
   always_comb begin
      wait_d = 8'd0;
      if (waiting_state && !ready && !timeout && (state_d == state_q))
         wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
   end

   // State and wait-counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: an instruction-level reference
// model expands each instruction into its expected per-cycle control trace.
module tb_multicycle_ctrl_fsm;

   localparam int T = 15;

   typedef struct packed {
      logic [3:0] st;
      logic       ir, adr, asa;
      logic [1:0] asb, rs, imm, regsrc;
      logic       regw, memw, pcw, br, lsrc, esca, nowr;
      logic [1:0] flagw;
      logic [2:0] aluc;
      logic       merr, undef;
   } rec_t;

   logic        clk = 1'b0;
   logic        reset, reset_b;
   logic [1:0]  Op;
   logic [5:0]  Funct;
   logic [3:0]  Rd;
   logic        shR, MemReady;
   logic [28:0] oa, ob;

   rec_t exp_q[$];
   bit   dut_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   bit         cur_dut = 1'b0;
   logic       p_rst_a = 1'b1, p_rst_b = 1'b1;
   logic [1:0] p_op = '0;
   logic [5:0] p_funct = '0;
   logic [3:0] p_rd = '0;
   logic       p_shr = 1'b0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.MEM_WAIT(1'b1), .EXT_OPS(1'b1), .TIMEOUT(T)) dut_a (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .shR(shR),
      .MemReady(MemReady), .IRWrite(oa[24]), .AdrSrc(oa[23]), .ALUSrcA(oa[22]),
      .ALUSrcB(oa[21:20]), .ResultSrc(oa[19:18]), .ImmSrc(oa[17:16]),
      .RegSrc(oa[15:14]), .RegW(oa[13]), .MemW(oa[12]), .PCWrite(oa[11]),
      .Branch(oa[10]), .LSrc(oa[9]), .EscaSrc(oa[8]), .NoWrite(oa[7]),
      .FlagW(oa[6:5]), .ALUControl(oa[4:2]), .MemErr(oa[1]), .Undef(oa[0]),
      .State(oa[28:25])
   );

   multicycle_ctrl_fsm #(.MEM_WAIT(1'b0), .EXT_OPS(1'b0), .TIMEOUT(T)) dut_b (
      .clk(clk), .reset(reset_b), .Op(Op), .Funct(Funct), .Rd(Rd), .shR(shR),
      .MemReady(MemReady), .IRWrite(ob[24]), .AdrSrc(ob[23]), .ALUSrcA(ob[22]),
      .ALUSrcB(ob[21:20]), .ResultSrc(ob[19:18]), .ImmSrc(ob[17:16]),
      .RegSrc(ob[15:14]), .RegW(ob[13]), .MemW(ob[12]), .PCWrite(ob[11]),
      .Branch(ob[10]), .LSrc(ob[9]), .EscaSrc(ob[8]), .NoWrite(ob[7]),
      .FlagW(ob[6:5]), .ALUControl(ob[4:2]), .MemErr(ob[1]), .Undef(ob[0]),
      .State(ob[28:25])
   );

   // Datapath selects each state presents; strobes are added by the trace builder.
   function automatic rec_t base(input int st);
      rec_t r = '0;
      r.st = 4'(st);
      case (st)
         0, 1: begin r.asa = 1'b1; r.asb = 2'b10; r.rs = 2'b10; end
         2:    begin r.asb = 2'b01; r.imm = 2'b01; end
         3:    r.adr = 1'b1;
         4:    r.rs = 2'b01;
         5:    begin r.adr = 1'b1; r.regsrc = 2'b10; end
         7:    r.asb = 2'b01;
         9:    begin r.asb = 2'b01; r.imm = 2'b10; r.rs = 2'b10; end
         default: ;
      endcase
      return r;
   endfunction

   // ALU operation table: defined flag, ALU code, compare-type flag.
   function automatic void alu_ref(input bit ext, input logic [3:0] f,
                                   output logic def, output logic [2:0] op,
                                   output logic nw);
      def = 1'b1; op = 3'd0; nw = 1'b0;
      case (f)
         4'b0100: op = 3'd0;
         4'b0010: op = 3'd1;
         4'b0000: op = 3'd2;
         4'b1100: op = 3'd3;
         4'b1101: op = 3'd4;
         4'b1010: begin op = 3'd1; nw = 1'b1; end
         4'b0001: if (ext) op = 3'd5; else def = 1'b0;
         4'b1110: if (ext) op = 3'd6; else def = 1'b0;
         4'b1000: if (ext) begin op = 3'd2; nw = 1'b1; end else def = 1'b0;
         default: def = 1'b0;
      endcase
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock of stimulus; its expected response goes to the scoreboard.
   task automatic drive(input rec_t e, input logic mr);
      @(posedge clk);
      #1;
      reset    = p_rst_a;
      reset_b  = p_rst_b;
      Op       = p_op;
      Funct    = p_funct;
      Rd       = p_rd;
      shR      = p_shr;
      MemReady = mr;
      exp_q.push_back(e);
      dut_q.push_back(cur_dut);
   endtask

   // A wait phase: n non-ready cycles then ready, or timeout when n exceeds T.
   // Returns 1 when the access completed.
   task automatic mem_phase(input int st, input int n, input rec_t done, output bit ok);
      rec_t e;
      int   k = cur_dut ? 0 : n;
      ok = 1'b0;
      e = base(st);
      if (st == 5) e.memw = 1'b1;
      if (k > T) begin
         repeat (T) drive(e, 1'b0);
         e = base(st);
         e.merr = 1'b1;
         drive(e, 1'b0);
      end else begin
         repeat (k) drive(e, 1'b0);
         drive(done, cur_dut ? 1'b0 : 1'b1);
         ok = 1'b1;
      end
   endtask

   // Expand one instruction into its full expected cycle trace.
   task automatic issue(input logic [1:0] op, input logic [5:0] funct,
                        input logic [3:0] rd, input logic shr,
                        input int fw, input int mw);
      rec_t e;
      bit   ok, def;
      logic [2:0] aop;
      logic nw;
      int   st;
      p_op = op; p_funct = funct; p_rd = rd; p_shr = shr;
      e = base(0); e.ir = 1'b1; e.pcw = 1'b1;
      mem_phase(0, fw, e, ok);
      if (!ok) return;
      e = base(1);
      e.undef = (op == 2'b11);
      drive(e, rbit());
      case (op)
         2'b10: begin
            e = base(9); e.br = 1'b1; e.pcw = 1'b1;
            drive(e, rbit());
            if (funct[4]) begin
               e = base(10); e.regw = 1'b1; e.lsrc = 1'b1;
               drive(e, rbit());
            end
         end
         2'b01: begin
            e = base(2);
            if (funct[5]) e.asb = 2'b00;
            drive(e, rbit());
            st = funct[0] ? 3 : 5;
            e = base(st);
            if (st == 5) e.memw = 1'b1;
            mem_phase(st, mw, e, ok);
            if (ok && st == 3) begin
               e = base(4); e.regw = 1'b1; e.pcw = (rd == 4'hF);
               drive(e, rbit());
            end
         end
         2'b00: begin
            alu_ref(!cur_dut, funct[4:1], def, aop, nw);
            e = base(funct[5] ? 7 : 6);
            if (!funct[5]) e.esca = shr;
            if (def) begin
               e.aluc  = aop;
               e.nowr  = nw;
               e.flagw = {funct[0], funct[0] & (aop < 3'd2)};
            end else begin
               e.undef = 1'b1;
               e.nowr  = 1'b1;
            end
            drive(e, rbit());
            if (!e.nowr) begin
               e = base(8); e.regw = 1'b1; e.pcw = (rd == 4'hF);
               drive(e, rbit());
            end
         end
         default: ;
      endcase
   endtask

   function automatic int rand_wait();
      int r = $urandom_range(0, 9);
      if (r == 0) return T + 1 + $urandom_range(0, 3);
      if (r < 4)  return $urandom_range(1, 4);
      return 0;
   endfunction

   // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
   initial begin
      rec_t e;
      bit   w;
      logic [28:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            w   = dut_q.pop_front();
            got = w ? ob : oa;
            vectors++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL ctrl_outputs dut%0d vec%0d: actual %h required %h (state %0d vs %0d)",
                        w, vectors, got, e, got[28:25], e.st);
            end
         end
      end
   end

   initial begin
      rec_t e;
      reset = 1'b1; reset_b = 1'b1; Op = '0; Funct = '0; Rd = '0;
      shR = 1'b0; MemReady = 1'b0;

      // Reset: FETCH with all strobes low even though memory is ready.
      repeat (2) drive(base(0), 1'b1);
      p_rst_a = 1'b0;

      issue(2'b00, 6'b101000, 4'd1, 1'b0, 0, 0);   // ADD R1,R2,#5
      issue(2'b00, 6'b010101, 4'd1, 1'b1, 0, 0);   // CMP R1,R2
      issue(2'b01, 6'b011001, 4'd3, 1'b0, 0, 3);   // LDR, 3 wait cycles
      issue(2'b01, 6'b111001, 4'd15, 1'b0, 2, 15); // LDR to PC, wait at limit
      issue(2'b01, 6'b011000, 4'd3, 1'b0, 0, 40);  // STR stuck: timeout
      issue(2'b10, 6'b010000, 4'd0, 1'b0, 0, 0);   // BL
      issue(2'b11, 6'b000000, 4'd0, 1'b0, 0, 0);   // undefined Op
      issue(2'b00, 6'b000010, 4'd15, 1'b0, 0, 0);  // EOR to PC
      issue(2'b00, 6'b110001, 4'd2, 1'b0, 0, 0);   // TST immediate
      issue(2'b00, 6'b000000, 4'd0, 1'b0, 30, 0);  // fetch timeout

      // Reset held three cycles in the middle of a store.
      p_op = 2'b01; p_funct = 6'b000000; p_rd = 4'd4; p_shr = 1'b0;
      e = base(0); e.ir = 1'b1; e.pcw = 1'b1; drive(e, 1'b1);
      drive(base(1), 1'b0);
      drive(base(2), 1'b0);
      e = base(5); e.memw = 1'b1;
      repeat (3) drive(e, 1'b0);
      p_rst_a = 1'b1;
      drive(base(5), 1'b1);
      repeat (2) drive(base(0), 1'b1);
      p_rst_a = 1'b0;
      issue(2'b00, 6'b011010, 4'd5, 1'b0, 0, 0);   // MOV resumes cleanly

      for (int i = 0; i < 150; i++)
         issue(2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom),
               rbit(), rand_wait(), rand_wait());

      // Second instance: no wait states, no extended ops.
      p_rst_a = 1'b1;
      p_rst_b = 1'b0;
      cur_dut = 1'b1;
      issue(2'b00, 6'b000010, 4'd1, 1'b0, 0, 0);   // EOR is undefined here
      issue(2'b00, 6'b111100, 4'd1, 1'b0, 0, 0);   // BIC is undefined here
      issue(2'b00, 6'b010001, 4'd1, 1'b0, 0, 0);   // TST is undefined here
      issue(2'b00, 6'b101000, 4'd1, 1'b0, 5, 0);   // ADD, MemReady ignored
      issue(2'b01, 6'b011001, 4'd2, 1'b0, 9, 40);  // LDR never waits
      for (int i = 0; i < 40; i++)
         issue(2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom),
               rbit(), rand_wait(), rand_wait());

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle successor to the single-cycle ARM control decoder; drives the shared-memory datapath, where one instruction takes 3–5 cycles.
- Moore main FSM plus a combinational ALU decoder.
- Adds memory wait states with a timeout, an extended ALU op set, and deterministic handling of undefined encodings.
- Sits between the instruction register and the condition-check logic. RegW, MemW and PCWrite are unconditional here; condition logic gates them downstream.

Parameters:
- MEM_WAIT, 1, 1: memory accesses wait for MemReady. 0: memory is treated as always ready.
- EXT_OPS, 1, 1: enables EOR, BIC and TST decoding.
- TIMEOUT, 15, maximum cycles spent waiting for MemReady before MemErr is raised; range 1–255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- shR  in  1  register-specified shift (Instr[4])
- MemReady  in  1  memory access complete this cycle
- IRWrite  out  1  load the instruction register
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ALUSrcA  out  1  0 = RD1, 1 = PC
- ALUSrcB  out  2  00 = RD2/shifted, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult
- ImmSrc  out  2  immediate-extend select
- RegSrc  out  2  register-address select
- RegW  out  1  register-file write enable
- MemW  out  1  memory write enable
- PCWrite  out  1  PC update
- Branch  out  1  branch state active
- LSrc  out  1  write destination is R14 (link)
- EscaSrc  out  1  shift amount taken from a register
- NoWrite  out  1  compare-type op; suppress register writeback
- FlagW  out  2  flag write: [1] = N,Z; [0] = C,V
- ALUControl  out  3  ALU operation
- MemErr  out  1  one-cycle pulse on memory timeout
- Undef  out  1  one-cycle pulse on an undefined instruction
- State  out  4  current state, for debug

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, BLWB 10. Unused encodings go to FETCH.
- Reset: the next state is FETCH and the wait counter is cleared. While reset is high, every enable and pulse output is 0 (IRWrite, RegW, MemW, PCWrite, Branch, MemErr, Undef). Reset mid-instruction abandons the instruction with no write strobe.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - IRWrite and PCWrite are high only in the cycle where ready is true; ready = MemReady, or 1 when MEM_WAIT=0.
  - On ready: go to DECODE. Otherwise stay in FETCH.
- DECODE: drives ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8). Next state:
  - Op=01 → MEMADR
  - Op=00 and Funct[5]=1 → EXECUTEI
  - Op=00 and Funct[5]=0 → EXECUTER
  - Op=10 → BRANCH
  - Op=11 → FETCH, with Undef pulsed for one cycle
- EXECUTER: ALUSrcA=0, ALUSrcB=00, EscaSrc=shR.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ImmSrc=00.
- Leaving EXECUTER/EXECUTEI: if NoWrite is set, go to FETCH; otherwise go to ALUWB.
- ALUWB: RegW=1, ResultSrc=00, then FETCH.
- MEMADR: ALUSrcB=01, ImmSrc=01. Register offset when Funct[5]=1. Go to MEMREAD if Funct[0]=1 (L), else MEMWRITE.
- MEMREAD: AdrSrc=1; on ready go to MEMWB.
- MEMWB: RegW=1, ResultSrc=01, then FETCH.
- MEMWRITE: AdrSrc=1, RegSrc=10, MemW=1 while waiting; on ready go to FETCH.
- BRANCH: Branch=1, ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=1. Next state is BLWB if Funct[4]=1, else FETCH.
- BLWB: RegW=1, LSrc=1, then FETCH.
- PC writeback: in ALUWB or MEMWB with Rd=15, PCWrite=1 in the same cycle as RegW.
- Wait counter:
  - Counts the consecutive non-ready cycles in FETCH, MEMREAD and MEMWRITE; clears on ready or on any state change.
  - When it reaches TIMEOUT: pulse MemErr, go to FETCH, and assert no write strobe that cycle.
  - The counter saturates and never wraps.
- ALU decoder: active only in EXECUTER/EXECUTEI; keyed on Funct[4:1].
  - 0100 ADD → 000
  - 0010 SUB → 001
  - 0000 AND → 010
  - 1100 ORR → 011
  - 1101 MOV → 100
  - 1010 CMP → 001, NoWrite=1
  - With EXT_OPS=1 only: 0001 EOR → 101; 1110 BIC → 110; 1000 TST → 010, NoWrite=1.
  - Any other code: ALUControl=000, NoWrite=1, Undef pulsed once, FlagW=00.
- Flags: FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 000 or 001). Both are 0 outside the EXECUTE states.
- Outside EXECUTE states: ALUControl=000, NoWrite=0.

Test Plan:
- reset held 3 cycles during MEMWRITE → State=0, MemW=0 throughout reset, and FETCH resumes on release.
- ADD R1,R2,#5 (Op=00, Funct=101000), MemReady=1 always → states 0,1,7,8,0; RegW=1 only in ALUWB; ALUControl=000.
- CMP R1,R2 (Funct=010101) → states 0,1,6,0; FlagW=11; NoWrite=1; RegW never asserted.
- LDR with MemReady low for 3 cycles in MEMREAD → stays in state 3 for 4 cycles, then MEMWB with RegW=1, ResultSrc=01.
- STR with MemReady stuck low, TIMEOUT=15 → MemErr pulses after 15 waiting cycles, then State=0, MemW=0 in the exit cycle.
- BL (Op=10, Funct[4]=1) → states 0,1,9,10,0 with LSrc=1 in BLWB. EOR with EXT_OPS=0 → Undef pulse and no RegW. Op=11 → Undef pulse in DECODE, then FETCH.
